// File: rtl/punc_debug_dumper_pkg.sv
// punc_debug_dumper_pkg: shared encodings for the PUnC debug dumper
package punc_debug_dumper_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SEND, ST_FIN} state_t;
  typedef enum logic [1:0] {PH_RF, PH_PC, PH_MEM} phase_t;
  localparam logic [1:0] TAG_RF = 2'd0;
  localparam logic [1:0] TAG_PC = 2'd1;
  localparam logic [1:0] TAG_MEM = 2'd2;
endpackage

// File: rtl/punc_debug_dumper_stream_reg.sv
// punc_debug_dumper_stream_reg: valid/ready holding stage for the dump stream
module punc_debug_dumper_stream_reg #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_tag,
  input  logic [ADDR_W-1:0] in_idx,
  input  logic              in_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_tag,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              fire
);
  assign fire = out_valid & out_ready;
  // word is held stable from load until the sink accepts it or it is cancelled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_tag <= '0;
      out_idx <= '0;
      out_last <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data <= in_data;
      out_tag <= in_tag;
      out_idx <= in_idx;
      out_last <= in_last;
    end else if (fire) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/punc_debug_dumper.sv
// punc_debug_dumper: walks RF, PC and a memory window out over a valid/ready stream
module punc_debug_dumper
  import punc_debug_dumper_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RF_REGS = 8,
  parameter int SETTLE_CYC = 1,
  parameter int RF_AW = $clog2(RF_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] mem_start,
  input  logic [ADDR_W-1:0] mem_count,
  output logic [ADDR_W-1:0] mem_debug_addr,
  output logic [RF_AW-1:0]  rf_debug_addr,
  input  logic [DATA_W-1:0] mem_debug_data,
  input  logic [DATA_W-1:0] rf_debug_data,
  input  logic [DATA_W-1:0] pc_debug_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_tag,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam int CW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  state_t state, nxt;
  phase_t phase;
  logic [ADDR_W-1:0] remaining;
  logic [CW-1:0] cnt;
  logic settle_last, accept, load, fire;
  logic [DATA_W-1:0] src_data;
  logic [1:0] src_tag;
  logic [ADDR_W-1:0] src_idx;
  logic src_last;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else state <= nxt;
  end
  // next state and the word source selected by the current phase
  always_comb begin
    settle_last = cnt == CW'(SETTLE_CYC - 1);
    accept = state == ST_IDLE && start && !abort;
    load = state == ST_SETTLE && settle_last && !abort;
    nxt = state;
    case (state)
      ST_IDLE: nxt = accept ? ST_SETTLE : ST_IDLE;
      ST_SETTLE: nxt = settle_last ? ST_SEND : ST_SETTLE;
      ST_SEND: nxt = !fire ? ST_SEND : out_last ? ST_FIN : ST_SETTLE;
      default: nxt = ST_IDLE;
    endcase
    if (abort) nxt = ST_IDLE;
    src_data = phase == PH_RF ? rf_debug_data : phase == PH_PC ? pc_debug_data : mem_debug_data;
    src_tag = phase == PH_RF ? TAG_RF : phase == PH_PC ? TAG_PC : TAG_MEM;
    src_idx = phase == PH_RF ? ADDR_W'(rf_debug_addr) : phase == PH_PC ? '0 : mem_debug_addr;
    src_last = phase == PH_PC ? remaining == '0 : phase == PH_MEM && remaining == ADDR_W'(1);
  end
  // walk pointers, settle counter and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_RF;
      rf_debug_addr <= '0;
      mem_debug_addr <= '0;
      remaining <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      cnt <= (state == ST_SETTLE && !settle_last) ? cnt + 1'b1 : '0;
      busy <= nxt == ST_SETTLE || nxt == ST_SEND;
      done <= nxt == ST_FIN;
      if (accept) begin
        phase <= PH_RF;
        rf_debug_addr <= '0;
        mem_debug_addr <= mem_start;
        remaining <= mem_count;
      end else if (state == ST_SEND && fire && !abort) begin
        if (phase == PH_RF) begin
          if (rf_debug_addr == RF_AW'(RF_REGS - 1)) phase <= PH_PC;
          else rf_debug_addr <= rf_debug_addr + 1'b1;
        end else if (phase == PH_PC) begin
          phase <= PH_MEM;
        end else begin
          mem_debug_addr <= mem_debug_addr + 1'b1;
          remaining <= remaining - 1'b1;
        end
      end
    end
  end
  punc_debug_dumper_stream_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_stream (
    .clk(clk),
    .rst(rst),
    .clr(abort),
    .load(load),
    .in_data(src_data),
    .in_tag(src_tag),
    .in_idx(src_idx),
    .in_last(src_last),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_tag(out_tag),
    .out_idx(out_idx),
    .out_last(out_last),
    .fire(fire)
  );
endmodule
